// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings,
// bounce direction constants, LED width and small decode helpers.
package led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        CHASE   = 2'd0,
        REVERSE = 2'd1,
        BOUNCE  = 2'd2,
        BLINK   = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One-hot LED image for a position index.
    function automatic logic [LED_W-1:0] posOneHot(input logic [1:0] pos);
        return LED_W'(1) << pos;
    endfunction

    // Mode sequence CHASE -> REVERSE -> BOUNCE -> BLINK -> CHASE.
    function automatic mode_e nextMode(input mode_e m);
        logic [1:0] v;
        v = m + 2'd1;
        return mode_e'(v);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Bring the raw button into the clock domain before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after a full run of samples that differ from it.
    always_comb begin
        level_d = level_q;
        count_d = count_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            count_d = '0;
        end else if (count_q == CNT_LAST) begin
            level_d = sync2_q;
            count_d = '0;
            press_d = sync2_q;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            count_q <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            count_q <= count_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern controller: a debounced button cycles through chase,
// reverse, bounce and blink modes; a tick divider paces the pattern.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV        = 1048576,
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             run,
    output logic [LED_W-1:0] leds,
    output logic [1:0]       mode
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              modeStep;
    logic              tick;
    logic [TICK_W-1:0] tickCnt_q;
    logic [TICK_W-1:0] tickCnt_d;
    mode_e             mode_q;
    mode_e             mode_d;
    logic [1:0]        pos_q;
    logic [1:0]        pos_d;
    logic              dir_q;
    logic              dir_d;
    logic              blinkOn_q;
    logic              blinkOn_d;
    logic [LED_W-1:0]  leds_q;
    logic [LED_W-1:0]  leds_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .press(modeStep)
    );

    // Tick fires on the last count of the divider, only while running.
    always_comb begin
        tick = run && (tickCnt_q == TICK_LAST);
    end

    // Next pattern state; a mode step restarts everything and swallows a tick.
    always_comb begin
        tickCnt_d = tickCnt_q;
        mode_d    = mode_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        blinkOn_d = blinkOn_q;
        if (modeStep) begin
            mode_d    = nextMode(mode_q);
            pos_d     = 2'd0;
            dir_d     = DIR_UP;
            blinkOn_d = 1'b1;
            tickCnt_d = '0;
        end else if (tick) begin
            tickCnt_d = '0;
            case (mode_q)
                CHASE:   pos_d = pos_q + 2'd1;
                REVERSE: pos_d = pos_q - 2'd1;
                BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == 2'd3) begin
                            pos_d = 2'd2;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + 2'd1;
                        end
                    end else begin
                        if (pos_q == 2'd0) begin
                            pos_d = 2'd1;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - 2'd1;
                        end
                    end
                end
                BLINK:   blinkOn_d = ~blinkOn_q;
                default: pos_d = pos_q;
            endcase
        end else if (run) begin
            tickCnt_d = tickCnt_q + 1'b1;
        end
    end

    // LED image of the current state, registered one cycle behind it.
    always_comb begin
        leds_d = posOneHot(pos_q);
        if (mode_q == BLINK) begin
            leds_d = {LED_W{blinkOn_q}};
        end
    end

    // All pattern registers, including the registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt_q <= '0;
            mode_q    <= CHASE;
            pos_q     <= 2'd0;
            dir_q     <= DIR_UP;
            blinkOn_q <= 1'b1;
            leds_q    <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
            mode_q    <= mode_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            blinkOn_q <= blinkOn_d;
            leds_q    <= leds_d;
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed vector tables, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_led_pattern_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

    typedef struct {
        logic       btn;
        logic       run;
        logic [3:0] expLeds;
        logic [1:0] expMode;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn   = 1'b0;
    logic       run   = 1'b0;
    logic [3:0] leds;
    logic [1:0] mode;

    int checkCnt = 0;
    int passCnt  = 0;

    // Reference model: button history, accepted level, pending press,
    // mode, number of pattern steps taken and phase inside a tick period.
    logic [15:0] mSh;
    logic        mLevel;
    logic        mPress;
    int          mMode;
    int          mStep;
    int          mPhase;
    logic [3:0]  mLeds;

    vec_t vecs[$];

    led_pattern_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .run  (run),
        .leds (leds),
        .mode (mode)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // LED image after k pattern steps in mode m.
    function automatic logic [3:0] modelLeds(input int m, input int k);
        int p;
        p = 0;
        case (m)
            0: p = k % 4;
            1: p = (4 - (k % 4)) % 4;
            2: begin
                p = k % 6;
                if (p > 3) p = 6 - p;
            end
            default: return ((k % 2) == 0) ? 4'b1111 : 4'b0000;
        endcase
        return 4'b0001 << p;
    endfunction

    task automatic checkVal(input string name, input logic [3:0] actual, input logic [3:0] required);
        checkCnt++;
        if (actual === required) passCnt++;
        else $display("[TB] FAIL %s: got %b, required %b", name, actual, required);
    endtask

    task automatic modelReset();
        mSh    = '0;
        mLevel = 1'b0;
        mPress = 1'b0;
        mMode  = 0;
        mStep  = 0;
        mPhase = 0;
        mLeds  = 4'b0000;
    endtask

    task automatic modelEdge(input logic b, input logic r);
        logic       accept;
        logic       pressNew;
        logic [3:0] newLeds;
        newLeds = modelLeds(mMode, mStep);
        mSh = {mSh[14:0], b};
        accept = 1'b1;
        for (int j = 0; j < DEB; j++) begin
            if (mSh[2+j] == mLevel) accept = 1'b0;
        end
        pressNew = accept && (mLevel == 1'b0);
        if (mPress) begin
            mMode  = (mMode + 1) % 4;
            mStep  = 0;
            mPhase = 0;
        end else if (r) begin
            if (mPhase == TICK_DIV - 1) begin
                mPhase = 0;
                mStep++;
            end else begin
                mPhase++;
            end
        end
        if (accept) mLevel = ~mLevel;
        mPress = pressNew;
        mLeds  = newLeds;
    endtask

    task automatic checkOutput();
        checkVal("model leds", leds, mLeds);
        checkVal("model mode", {2'b00, mode}, 4'(mMode));
    endtask

    task automatic applyStimulus(input logic b, input logic r);
        btn = b;
        run = r;
        @(posedge clk);
        modelEdge(b, r);
        #1;
        checkOutput();
    endtask

    task automatic assertReset();
        btn   = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkVal("reset leds", leds, 4'b0000);
        checkVal("reset mode", {2'b00, mode}, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("held reset leds", leds, 4'b0000);
        checkVal("held reset mode", {2'b00, mode}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pressButton(input logic r);
        repeat (4) applyStimulus(1'b1, r);
        repeat (8) applyStimulus(1'b0, r);
    endtask

    task automatic addVec(input logic b, input logic r, input logic [3:0] l, input logic [1:0] m);
        vec_t v;
        v.btn     = b;
        v.run     = r;
        v.expLeds = l;
        v.expMode = m;
        vecs.push_back(v);
    endtask

    task automatic runTable(input string name);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btn, vecs[i].run);
            checkVal({name, " leds"}, leds, vecs[i].expLeds);
            checkVal({name, " mode"}, {2'b00, mode}, {2'b00, vecs[i].expMode});
        end
        vecs.delete();
    endtask

    initial begin
        logic [9:0]  bouncePat;
        logic [31:0] bounceSeq;
        logic        rb;
        logic        rr;

        modelReset();
        #2;

        // Chase after reset: each LED held for one tick period.
        assertReset();
        for (int i = 0; i < 20; i++) addVec(1'b0, 1'b1, 4'b0001 << ((i / 4) % 4), 2'd0);
        runTable("chase");

        // Short pulse and bounce are rejected; a long press steps exactly once.
        assertReset();
        bouncePat = 10'b0000101011;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(bouncePat[i], 1'b1);
            checkVal("bounce no step", {2'b00, mode}, 4'd0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkVal("press mode", {2'b00, mode}, (i < 5) ? 4'd0 : 4'd1);
        end
        applyStimulus(1'b0, 1'b1);
        checkVal("press leds restart", leds, 4'b0001);
        checkVal("press mode held", {2'b00, mode}, 4'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkVal("single step", {2'b00, mode}, 4'd1);
        end

        // Bounce sequence.
        assertReset();
        pressButton(1'b0);
        pressButton(1'b0);
        checkVal("bounce mode", {2'b00, mode}, 4'd2);
        bounceSeq = {4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 32; i++) addVec(1'b0, 1'b1, bounceSeq[4*(i/4) +: 4], 2'd2);
        runTable("bounce");

        // Blink, then wrap back to chase.
        pressButton(1'b0);
        checkVal("blink mode", {2'b00, mode}, 4'd3);
        for (int i = 0; i < 16; i++) addVec(1'b0, 1'b1, (((i / 4) % 2) == 0) ? 4'b1111 : 4'b0000, 2'd3);
        runTable("blink");
        pressButton(1'b0);
        checkVal("wrap mode", {2'b00, mode}, 4'd0);
        checkVal("wrap leds", leds, 4'b0001);

        // Freezing mid-period resumes with the remaining count.
        assertReset();
        repeat (9) applyStimulus(1'b0, 1'b1);
        checkVal("freeze start", leds, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkVal("frozen leds", leds, 4'b0100);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkVal("resume wait", leds, 4'b0100);
        end
        applyStimulus(1'b0, 1'b1);
        checkVal("resume step", leds, 4'b1000);

        // Mode step lands on a tick edge: the step wins and the tick is lost.
        assertReset();
        repeat (2) applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkVal("pre-collision mode", {2'b00, mode}, 4'd0);
        applyStimulus(1'b0, 1'b1);
        checkVal("collision mode", {2'b00, mode}, 4'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkVal("collision leds", leds, 4'b0001);
        end
        applyStimulus(1'b0, 1'b1);
        checkVal("reverse first step", leds, 4'b1000);

        // Reset mid-debounce, then reset with a press pending.
        repeat (3) applyStimulus(1'b1, 1'b1);
        assertReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkVal("no press after reset", {2'b00, mode}, 4'd0);
        end
        repeat (5) applyStimulus(1'b1, 1'b1);
        assertReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkVal("no stale press", {2'b00, mode}, 4'd0);
        end

        // Randomized button/run activity with occasional resets.
        assertReset();
        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            rr = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 599) == 0) begin
                assertReset();
                rb = 1'b0;
            end
            applyStimulus(rb, rr);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1048576, clk cycles per pattern step; SHALL be >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 60000, consecutive stable cycles needed to accept a button level; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn  input  1  raw asynchronous mode button, active-high, bouncy.
REQ-006 run  input  1  1 = pattern advances; 0 = pattern frozen.
REQ-007 leds  output  4  registered LED drive, active-high, bit 0 = LED1.
REQ-008 mode  output  2  current pattern mode, registered.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 The debounced level SHALL take the synchronized value only after DEBOUNCE_CYCLES consecutive identical samples; any differing sample SHALL restart the count.
REQ-011 A debounced 0->1 transition SHALL produce a one-cycle mode_step pulse; 1->0 produces nothing.
REQ-012 Modes: CHASE=0, REVERSE=1, BOUNCE=2, BLINK=3; each mode_step SHALL advance the mode by 1, with BLINK wrapping to CHASE.
REQ-013 The tick counter SHALL count 0..TICK_DIV-1 while run=1, emit a one-cycle tick at TICK_DIV-1, then wrap to 0; while run=0 it SHALL hold its value and emit no tick.
REQ-014 Pattern state: pos[1:0], dir (0=up), blink_on.
REQ-015 CHASE: each tick SHALL increment pos, wrapping 3->0.
REQ-016 REVERSE: each tick SHALL decrement pos, wrapping 0->3.
REQ-017 BOUNCE: each tick SHALL move pos one step in direction dir; at pos=3 going up, pos SHALL become 2 with dir=down; at pos=0 going down, pos SHALL become 1 with dir=up. The sequence is 0,1,2,3,2,1,0,1,...
REQ-018 BLINK: each tick SHALL toggle blink_on.
REQ-019 On mode_step, the block SHALL set pos=0, dir=up, blink_on=1 and tick counter=0 in the same edge that updates mode.
REQ-020 When mode_step and tick coincide, mode_step SHALL win and the tick SHALL be discarded.
REQ-021 mode_step SHALL be honoured regardless of run.
REQ-022 leds SHALL be a registered decode of the state: one-hot(pos) in CHASE, REVERSE and BOUNCE; 4'b1111 when blink_on=1 in BLINK, else 4'b0000.
REQ-023 leds SHALL lag the state registers by exactly one clk cycle; exactly one LED SHALL be lit in the non-BLINK modes.
REQ-024 The mode output SHALL equal the mode register with no added latency.

Reset
REQ-025 While rst_n=0, the block SHALL hold synchronizer flops=0, debounced level=0, debounce count=0, tick counter=0, mode=CHASE, pos=0, dir=up, blink_on=1 and leds=4'b0000.
REQ-026 On the first clk edge after rst_n deasserts, leds SHALL become 4'b0001.
REQ-027 Reset asserted mid-pattern or mid-debounce SHALL abort the operation immediately; no pending mode_step SHALL survive reset.

Structure
REQ-028 Shared package led_pkg SHALL hold the mode encodings (CHASE/REVERSE/BOUNCE/BLINK), the direction constants and the LED width constant (4).
REQ-029 Synchronizer, debouncer and rising-edge detector SHALL form one sub-module, btn_debounce (ports clk, rst_n, btn, press), parameterised by DEBOUNCE_CYCLES.
REQ-030 The tick counter width SHALL be $clog2(TICK_DIV); no other sub-modules.

Verification (bench uses TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-031 Release reset, run=1, btn=0 -> leds 0001,0010,0100,1000,0001, each held 4 cycles; mode=0 throughout.
REQ-032 btn pulses high for 2 cycles and then bounces 1-0-1 -> no mode change; btn held high for 6 cycles -> mode goes 0->1 exactly once, and leds=0001 one cycle after the mode changes.
REQ-033 Mode BOUNCE, run=1 -> leds sequence 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-034 Mode BLINK -> leds alternate 1111/0000 every 4 cycles; one further press -> mode=0 and leds=0001.
REQ-035 run=0 for 10 cycles in CHASE at pos=2 -> leds stay 0100; after run=1 the next step occurs after the remaining tick count, not a full period.
REQ-036 Press completing on the same cycle as a tick, then rst_n pulsed low mid-debounce -> mode_step wins with pos=0; during reset leds=0000 and mode=0, and no stale press is seen afterwards.
